// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Operands arrive through a valid/ready handshake. The result is held in DONE until the
// consumer accepts it.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  packed BCD operands, digit i = x[4i+3:4i]
//   cin                   carry-in (add) / borrow-in (sub)
//   sub                   0: A+B+cin, 1: A-B-cin
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   sum                   packed BCD result
//   cout                  add: decimal carry-out; sub: 1 = no borrow
//   err                   an operand digit was > 9 (sum/cout forced to 0)
//   busy                  state != IDLE
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4,
    localparam int unsigned W = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err,
    output logic         busy
);

    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic              inv_q, inv_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [3:0]        b_eff;
    logic [4:0]        raw;
    logic [3:0]        digit;
    logic              digit_carry;

    // True when any 4-bit digit of x is not a legal BCD value.
    function automatic logic has_bad_digit(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Shared single-digit datapath; operands are shifted down so the current digit sits in [3:0].
    always_comb begin
        b_eff       = sub_q ? 4'(4'd9 - b_q[3:0]) : b_q[3:0];
        raw         = {1'b0, a_q[3:0]} + {1'b0, b_eff} + {4'b0000, carry_q};
        digit       = raw[3:0];
        digit_carry = 1'b0;
        if (raw > 5'd9) begin
            digit       = 4'(raw[3:0] + 4'd6);
            digit_carry = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        inv_d       = inv_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    sub_d      = sub;
                    // Subtraction runs as A + 9's-complement(B) + ~borrow.
                    carry_d    = sub ? ~cin : cin;
                    inv_d      = has_bad_digit(a) | has_bad_digit(b);
                    idx_d      = '0;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    err_d      = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (inv_q) begin
                    // Illegal operand: report after one cycle with sum/cout left cleared.
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    sum_d[{idx_q, 2'b00} +: 4] = digit;
                    a_d     = a_q >> 4;
                    b_d     = b_q >> 4;
                    carry_d = digit_carry;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDXW'(DIGITS - 1)) begin
                        cout_d      = digit_carry;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            inv_q       <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            inv_q       <= inv_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub at DIGITS = 4, 1 and 8.
module tb_bcd_serial_addsub;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic        iv4, ir4, ci4, sb4, ov4, or4, co4, er4, bz4;
    logic [15:0] a4, b4, s4;
    logic        iv1, ir1, ci1, sb1, ov1, or1, co1, er1, bz1;
    logic [3:0]  a1, b1, s1;
    logic        iv8, ir8, ci8, sb8, ov8, or8, co8, er8, bz8;
    logic [31:0] a8, b8, s8;

    bcd_serial_addsub #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4),
        .err(er4), .busy(bz4));

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1),
        .err(er1), .busy(bz1));

    bcd_serial_addsub #(.DIGITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
        .err(er8), .busy(bz8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
        int n;
        n = 0;
        while (!ir4 && n < 20) begin @(posedge clk); #1; n++; end
        chk("start4_ready", 64'(ir4), 64'd1);
        iv4 = 1'b1; a4 = a; b4 = b; ci4 = ci; sb4 = s;
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic wait4(input int n0, output int n);
        n = n0;
        while (!ov4 && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s, input logic [15:0] es,
                       input logic ec, input logic ee, input int elat);
        int n;
        or4 = 1'b1;
        start4(a, b, ci, s);
        wait4(0, n);
        chk({tag, "_lat"},  64'(n),   64'(elat));
        chk({tag, "_sum"},  64'(s4),  64'(es));
        chk({tag, "_cout"}, 64'(co4), 64'(ec));
        chk({tag, "_err"},  64'(er4), 64'(ee));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'({ir4, ov4, bz4}), 64'b100);
    endtask

    task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic s, input logic [3:0] es,
                       input logic ec, input logic ee);
        int n;
        or1 = 1'b1;
        n = 0;
        while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
        iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci; sb1 = s;
        @(posedge clk); #1;
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"},  64'(n),   64'd1);
        chk({tag, "_sum"},  64'(s1),  64'(es));
        chk({tag, "_cout"}, 64'(co1), 64'(ec));
        chk({tag, "_err"},  64'(er1), 64'(ee));
        @(posedge clk); #1;
    endtask

    task automatic op8(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic s, input logic [31:0] es, input logic ec);
        int n;
        or8 = 1'b1;
        n = 0;
        while (!ir8 && n < 20) begin @(posedge clk); #1; n++; end
        iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci; sb8 = s;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"},  64'(n),   64'd8);
        chk({tag, "_sum"},  64'(s8),  64'(es));
        chk({tag, "_cout"}, 64'(co8), 64'(ec));
        chk({tag, "_err"},  64'(er8), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic longint bcd2int(input logic [31:0] x);
        longint v;
        v = 0;
        for (int i = 7; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] r;
        longint      t;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] ra, rb, es;
        logic        rc, rs, ec;
        longint      va, vb, vr;

        tests = 0; fails = 0;
        iv4 = 0; a4 = '0; b4 = '0; ci4 = 0; sb4 = 0; or4 = 1;
        iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; sb1 = 0; or1 = 1;
        iv8 = 0; a8 = '0; b8 = '0; ci8 = 0; sb8 = 0; or8 = 1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_sum",   64'(s4), 64'd0);
        chk("reset_flags", 64'({ir4, ov4, bz4, co4, er4}), 64'b10000);
        #18 rst_n = 1'b1;
        @(posedge clk); #1;

        // Addition, wrap and subtraction
        op4("t1_add",    16'h1234, 16'h5678, 0, 0, 16'h6912, 0, 0, 4);
        op4("t2_wrap",   16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, 4);
        op4("t2_max",    16'h9999, 16'h9999, 1, 0, 16'h9999, 1, 0, 4);
        op4("add_cin",   16'h0500, 16'h0499, 1, 0, 16'h1000, 0, 0, 4);
        op4("t3_sub",    16'h5000, 16'h1234, 0, 1, 16'h3766, 1, 0, 4);
        op4("t3_neg",    16'h1234, 16'h5000, 0, 1, 16'h6234, 0, 0, 4);
        op4("t3_borrow", 16'h0000, 16'h0000, 1, 1, 16'h9999, 0, 0, 4);
        op4("sub_bin",   16'h1000, 16'h0001, 1, 1, 16'h0998, 1, 0, 4);

        // Illegal digits in either operand
        op4("t4_bad_a",  16'h12A4, 16'h0000, 0, 0, 16'h0000, 0, 1, 1);
        op4("t4_bad_b",  16'h9999, 16'h000F, 0, 1, 16'h0000, 0, 1, 1);
        op4("after_err", 16'h0042, 16'h0058, 0, 0, 16'h0100, 0, 0, 4);

        // Back-pressure in DONE and in_valid pulse during RUN
        or4 = 1'b0;
        start4(16'h4444, 16'h4444, 0, 0);
        iv4 = 1'b1; a4 = 16'h1111; b4 = 16'h1111;
        @(posedge clk); #1;
        iv4 = 1'b0;
        wait4(1, n);
        chk("t5_lat", 64'(n),  64'd4);
        chk("t5_sum", 64'(s4), 64'h8888);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_sum",   64'(s4), 64'h8888);
            chk("t5_hold_flags", 64'({ir4, ov4, bz4, co4, er4}), 64'b01100);
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        chk("t5_release",  64'({ir4, ov4, bz4}), 64'b100);
        chk("t5_idle_sum", 64'(s4), 64'h8888);

        // Reset in the middle of RUN
        start4(16'h1234, 16'h5678, 0, 0);
        @(posedge clk); #1;
        chk("t5_midrun_sum", 64'(s4), 64'h0002);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sum",   64'(s4), 64'd0);
        chk("t5_rst_flags", 64'({ir4, ov4, bz4, co4, er4}), 64'b10000);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_after", 64'({ir4, ov4, bz4}), 64'b100);
        op4("t5_recover", 16'h0500, 16'h0499, 1, 0, 16'h1000, 0, 0, 4);

        // Single-digit instance
        op1("t6_d1_add", 4'h9, 4'h9, 1, 0, 4'h9, 1, 0);
        op1("t6_d1_sub", 4'h5, 4'h7, 0, 1, 4'h8, 0, 0);
        op1("t6_d1_bad", 4'hC, 4'h1, 0, 0, 4'h0, 0, 1);

        // Eight-digit instance: directed, then random against a decimal model
        op8("t6_d8_wrap", 32'h99999999, 32'h00000001, 0, 0, 32'h00000000, 1);
        op8("t6_d8_neg",  32'h12345678, 32'h87654321, 0, 1, 32'h24691357, 0);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            va = bcd2int(ra);
            vb = bcd2int(rb);
            if (rs) begin
                vr = va - vb - longint'(rc);
                ec = (vr >= 0);
                if (vr < 0) vr = vr + 100000000;
            end else begin
                vr = va + vb + longint'(rc);
                ec = (vr >= 100000000);
                if (vr >= 100000000) vr = vr - 100000000;
            end
            es = int2bcd(vr);
            op8("t6_d8_rand", ra, rb, rc, rs, es, ec);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
